// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative unsigned multiply/divide/modulo engine
//
// Computes one result bit per clock. The control unit holds req_valid high
// while a MUL/DIV/MOD instruction is decoded, and stalls on ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid         multicycle instruction present
//   op                00 mul, 01 div, 10 mod, 11 mul
//   src_a, src_b      multiplicand/dividend, multiplier/divisor
//   ready             instruction may complete this cycle
//   res_lo            mul: product low; div: quotient; mod: remainder
//   res_hi            mul: product high; div/mod: remainder
//   flags             {ZF, NF, CF, OF}
//   busy              engine iterating

module muldiv_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             ready,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic [3:0]       flags,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic               div_q;
   logic               mod_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;

   // Shared working register: {hi, lo} for mul, {rem, quot} for div/mod.
   // The mul carry bit is shifted straight into hi[MSB] in the same cycle,
   // so it never needs its own storage bit.
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;

   logic [WIDTH-1:0]   fin_lo;
   logic [WIDTH-1:0]   fin_hi;
   logic [3:0]         fin_flags;

   logic               in_divlike;
   logic               dz;
   logic [WIDTH-1:0]   dz_lo;

   assign ready = ~req_valid | (state == S_DONE);
   assign busy  = (state == S_BUSY);

   // One iteration of either algorithm, from the latched operands.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_trial = div_shift - {1'b0, b_q};
      acc_nxt   = acc;
      if (div_q | mod_q) begin
         // A borrow out of the W+1-bit subtract means the trial failed.
         if (!div_trial[WIDTH])
            acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         if (acc[0])
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
         else
            acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
      end
   end

   // Results and flags as they will look after the final iteration.
   always_comb begin
      fin_lo    = acc_nxt[WIDTH-1:0];
      fin_hi    = acc_nxt[2*WIDTH-1:WIDTH];
      fin_flags = '0;
      if (mod_q)
         fin_lo = acc_nxt[2*WIDTH-1:WIDTH];
      if (div_q | mod_q) begin
         fin_flags = {(fin_lo == '0), fin_lo[WIDTH-1], 1'b0, 1'b0};
      end else begin
         fin_flags = {(acc_nxt == '0), fin_lo[WIDTH-1],
                      (fin_hi != '0), (fin_hi != '0)};
      end
   end

   // Divide-by-zero is resolved from the live inputs in the accept cycle.
   always_comb begin
      in_divlike = (op == 2'b01) || (op == 2'b10);
      dz         = in_divlike && (src_b == '0);
      dz_lo      = (op == 2'b01) ? {WIDTH{1'b1}} : src_a;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         count  <= '0;
         acc    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         div_q  <= 1'b0;
         mod_q  <= 1'b0;
         res_lo <= '0;
         res_hi <= '0;
         flags  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  a_q   <= src_a;
                  b_q   <= src_b;
                  div_q <= (op == 2'b01);
                  mod_q <= (op == 2'b10);
                  count <= '0;
                  if (dz) begin
                     res_lo <= dz_lo;
                     res_hi <= src_a;
                     flags  <= {(dz_lo == '0), dz_lo[WIDTH-1], 1'b0, 1'b1};
                     state  <= S_DONE;
                  end else begin
                     // Mul preloads lo with the multiplier; div preloads
                     // quot with the dividend so it shifts into rem.
                     acc   <= {{WIDTH{1'b0}}, in_divlike ? src_a : src_b};
                     state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (!req_valid) begin
                  state <= S_IDLE;
               end else begin
                  acc   <= acc_nxt;
                  count <= count + CNT_W'(1);
                  if (count == LAST_ITER) begin
                     res_lo <= fin_lo;
                     res_hi <= fin_hi;
                     flags  <= fin_flags;
                     state  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
